// File: rtl/bht_update_queue_if.sv
// Execute-to-predictor update bus for bht_update_queue.
// With BUQ_PERF_EN defined the bus also carries the stall_cnt counter.
interface bht_update_queue_if #(
    parameter int DEPTH = 8
);
    logic [1:0]                     in_valid;
    logic [1:0][31:0]               in_pc;
    logic [1:0]                     in_taken;
    logic                           in_ready;
    logic                           update_en;
    logic [31:0]                    pc_dispatch;
    logic                           taken_actual;
    logic [$clog2(DEPTH+1)-1:0]     count;
`ifdef BUQ_PERF_EN
    logic [31:0]                    stall_cnt;
`endif

    modport master (
        output in_valid, in_pc, in_taken,
        input  in_ready, update_en, pc_dispatch, taken_actual, count
`ifdef BUQ_PERF_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  in_valid, in_pc, in_taken,
        output in_ready, update_en, pc_dispatch, taken_actual, count
`ifdef BUQ_PERF_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/bht_update_queue.sv
// Two-in / one-out in-order queue feeding resolved branches to the BHT/PHT update port.
// Optional feature macro: BUQ_PERF_EN adds a saturating backpressure stall counter.
module bht_update_queue #(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    bht_update_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Storage is never reset; only pointers and occupancy are.
    logic [31:0]      r_pc [DEPTH];
    logic [DEPTH-1:0] r_tk;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_ready;
    logic             w_push0;
    logic             w_push1;
    logic [1:0]       w_npush;
    logic             w_pop;
    logic [PW-1:0]    w_slot1_idx;
    logic [CW-1:0]    w_count_next;

    assign w_ready      = (r_count <= CW'(DEPTH - 2));
    assign w_push0      = w_ready & q.in_valid[0];
    assign w_push1      = w_ready & q.in_valid[1];
    assign w_npush      = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_pop        = (r_count != '0);
    // Slot 1 lands right behind slot 0 only when slot 0 is also written.
    assign w_slot1_idx  = w_push0 ? r_tail + PW'(1) : r_tail;
    assign w_count_next = r_count + CW'(w_npush) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_pc[r_tail] <= q.in_pc[0];
            r_tk[r_tail] <= q.in_taken[0];
        end
        if (w_push1) begin
            r_pc[w_slot1_idx] <= q.in_pc[1];
            r_tk[w_slot1_idx] <= q.in_taken[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_npush);
            r_head  <= r_head + PW'(w_pop);
            r_count <= w_count_next;
        end
    end

    assign q.in_ready     = w_ready;
    assign q.update_en    = w_pop;
    assign q.pc_dispatch  = w_pop ? r_pc[r_head] : 32'h0;
    assign q.taken_actual = w_pop ? r_tk[r_head] : 1'b0;
    assign q.count        = r_count;

`ifdef BUQ_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((q.in_valid != 2'b00) && !w_ready) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign q.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue: directed steps plus random traffic
// compared every cycle against a queue-based reference model.
module tb_bht_update_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bht_update_queue_if #(.DEPTH(DEPTH)) bus();
    bht_update_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));

    logic [32:0] mq[$];      // {pc, taken}, front = oldest
    int          m_stall;
    int          accepted;
    int          dut_updates;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_pc;
        logic        exp_tk;
        exp_pc = (mq.size() != 0) ? mq[0][32:1] : 32'h0;
        exp_tk = (mq.size() != 0) ? mq[0][0]    : 1'b0;
        chk({tag, ".update_en"},    32'(bus.update_en),    32'(mq.size() != 0));
        chk({tag, ".pc_dispatch"},  bus.pc_dispatch,       exp_pc);
        chk({tag, ".taken_actual"}, 32'(bus.taken_actual), 32'(exp_tk));
        chk({tag, ".count"},        32'(bus.count),        32'(mq.size()));
        chk({tag, ".in_ready"},     32'(bus.in_ready),     32'(mq.size() <= DEPTH - 2));
`ifdef BUQ_PERF_EN
        chk({tag, ".stall_cnt"},    bus.stall_cnt,         32'(m_stall));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input string tag, input logic [1:0] v, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [1:0] t, input logic r);
        bit rdy;
        bus.in_valid = v;
        bus.in_pc    = {p1, p0};
        bus.in_taken = t;
        rst          = r;
        if (bus.update_en === 1'b1) dut_updates++;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_stall = 0;
        end else begin
            rdy = (mq.size() <= DEPTH - 2);
            if (v != 2'b00 && !rdy) m_stall++;
            if (mq.size() != 0) void'(mq.pop_front());
            if (rdy && v[0]) begin mq.push_back({p0, t[0]}); accepted++; end
            if (rdy && v[1]) begin mq.push_back({p1, t[1]}); accepted++; end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        m_stall     = 0;
        accepted    = 0;
        dut_updates = 0;
        bus.in_valid = 2'b00;
        bus.in_pc    = '0;
        bus.in_taken = 2'b00;
        rst          = 1'b1;

        step("reset0", 2'b00, 0, 0, 2'b00, 1'b1);
        step("reset1", 2'b00, 0, 0, 2'b00, 1'b0);

        // Build up four entries, then reset mid-operation.
        step("fill_a", 2'b11, 32'hA000_0000, 32'hA000_0004, 2'b01, 1'b0);
        step("fill_b", 2'b11, 32'hA000_0008, 32'hA000_000C, 2'b10, 1'b0);
        step("fill_c", 2'b11, 32'hA000_0010, 32'hA000_0014, 2'b11, 1'b0);
        chk("half_full_count", 32'(bus.count), 32'd4);
        step("mid_reset", 2'b11, 32'hBAD0_0000, 32'hBAD0_0004, 2'b11, 1'b1);
        chk("post_reset_count",  32'(bus.count),     32'd0);
        chk("post_reset_upd",    32'(bus.update_en), 32'd0);
        chk("post_reset_ready",  32'(bus.in_ready),  32'd1);
        chk("post_reset_pc",     bus.pc_dispatch,    32'h0);

        // Single push on slot 0.
        step("single", 2'b01, 32'h1C00_0010, 32'h0, 2'b01, 1'b0);
        chk("single_pc",    bus.pc_dispatch,       32'h1C00_0010);
        chk("single_taken", 32'(bus.taken_actual), 32'd1);
        step("single_drain", 2'b00, 0, 0, 2'b00, 1'b0);
        chk("single_after", 32'(bus.update_en), 32'd0);

        // Dual push drains slot 0 then slot 1.
        step("dual", 2'b11, 32'h1C00_0020, 32'h1C00_0024, 2'b01, 1'b0);
        chk("dual_first_pc", bus.pc_dispatch, 32'h1C00_0020);
        chk("dual_first_tk", 32'(bus.taken_actual), 32'd1);
        step("dual_2", 2'b00, 0, 0, 2'b00, 1'b0);
        chk("dual_second_pc", bus.pc_dispatch, 32'h1C00_0024);
        chk("dual_second_tk", 32'(bus.taken_actual), 32'd0);
        step("dual_3", 2'b00, 0, 0, 2'b00, 1'b0);

        // Slot-1-only push.
        step("slot1", 2'b10, 32'hDEAD_0000, 32'h1C00_0030, 2'b10, 1'b0);
        chk("slot1_pc", bus.pc_dispatch, 32'h1C00_0030);
        chk("slot1_tk", 32'(bus.taken_actual), 32'd1);
        step("slot1_after", 2'b00, 0, 0, 2'b00, 1'b0);

        // Sustained dual push: fills, toggles in_ready, wraps pointers.
        accepted    = 0;
        dut_updates = 0;
        for (int i = 0; i < 24; i++) begin
            step("sustain", 2'b11, 32'h2000_0000 + 32'(8 * i), 32'h2000_0004 + 32'(8 * i),
                 2'($urandom), 1'b0);
            if (i == 5) chk("sustain_count7_ready", 32'(bus.in_ready), 32'd0);
        end
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++)
            step("drain", 2'b00, 0, 0, 2'b00, 1'b0);
        chk("drain_empty", 32'(bus.count), 32'd0);
        step("drain_tail", 2'b00, 0, 0, 2'b00, 1'b0);
        chk("total_updates", 32'(dut_updates), 32'(accepted));

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step("random", 2'($urandom), $urandom, $urandom, 2'($urandom),
                 ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Buffers resolved-branch outcomes from the two execute pipes and drains them, one per cycle and in program order, into the single update port of the dual-issue BHT/PHT direction predictor. Execute can resolve two branches per cycle, but the predictor table accepts only one update per cycle. This block absorbs that rate mismatch, applies backpressure to execute, and drives the predictor's `update_en` / `pc_dispatch` / `taken_actual` inputs directly.

## Interface
- `DEPTH`, 8: number of queue entries; power of two, at least 4.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  2  per-slot resolved-branch valid; slot 0 is older than slot 1
- `in_pc`  in  2x32  per-slot branch PC (packed `[1:0][31:0]`)
- `in_taken`  in  2  per-slot actual direction (1 = taken)
- `in_ready`  out  1  queue can accept two entries this cycle
- `update_en`  out  1  head entry valid; predictor consumes it this cycle
- `pc_dispatch`  out  32  head entry PC
- `taken_actual`  out  1  head entry direction
- `count`  out  $clog2(DEPTH+1)  current occupancy
- `stall_cnt`  out  32  present only with `BUQ_PERF_EN`; see Configuration

## Operation
- Storage is a circular buffer of {pc[31:0], taken}, with a head pointer, a tail pointer (each $clog2(DEPTH) bits, wrapping at DEPTH) and an occupancy counter.
- `in_ready = (count <= DEPTH-2)`. It is computed from the registered count only; a same-cycle pop does not raise it.
- Push, when `in_ready=1`:
  - `in_valid=2'b11`: slot 0 goes to tail, slot 1 to tail+1; tail advances by 2.
  - `2'b01`: slot 0 only. `2'b10`: slot 1 only. Each advances tail by 1.
  - `2'b00`: no write.
- When `in_ready=0`, all inputs are ignored: no write, no pointer change. Execute holds its outputs until ready.
- Pop:
  - `update_en = (count != 0)`.
  - `pc_dispatch` and `taken_actual` are driven from storage at head. They read 0 when the queue is empty.
  - The predictor always accepts, so head advances by 1 on every cycle with `update_en=1`.
- Simultaneous push and pop: `count_next = count + pushes - pop`. Here pushes is 0, 1 or 2 and pop is 0 or 1. Count never exceeds DEPTH and never underflows.
- Order is preserved globally: older cycles first, and slot 0 before slot 1 within a cycle.
- Reset:
  - Clears head, tail and count (and `stall_cnt`).
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all pending entries. The cycle after reset: `update_en=0`, `pc_dispatch=0`, `taken_actual=0`, `count=0`, `in_ready=1`.

## Timing
- Push-to-update latency is 1 cycle. An entry written at edge t into an empty queue appears with `update_en=1` in the cycle following edge t.
- A two-entry push into an empty queue drains over the next 2 cycles (slot 0, then slot 1).
- Throughput: 1 update per cycle sustained. With 2 pushes per cycle sustained, the queue fills after roughly DEPTH-1 cycles, then `in_ready` toggles.
- All outputs come from flops, or from storage muxed by registered head and count. There are no combinational input-to-output paths.

## Configuration
- `BUQ_PERF_EN` defined:
  - Adds the 32-bit `stall_cnt` output.
  - It increments on every cycle with `in_valid != 0 && in_ready == 0`, and saturates at 32'hFFFF_FFFF.
  - Reset clears it to 0.
- `BUQ_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset with the queue half full (4 entries) → next cycle `count=0`, `update_en=0`, `in_ready=1`, `pc_dispatch=0`.
- Single push: `in_valid=2'b01`, `pc=32'h1C00_0010`, taken=1 on an empty queue → next cycle `update_en=1`, `pc_dispatch=32'h1C00_0010`, `taken_actual=1`; the cycle after, `update_en=0`.
- Dual push: `{pc1,pc0}={32'h...24, 32'h...20}`, taken={0,1} → two consecutive updates in order `...20`/1 then `...24`/0.
- Slot-1-only push (`in_valid=2'b10`) → exactly one update carrying slot 1's PC and direction.
- Sustained `2'b11` every cycle, DEPTH=8:
  - `in_ready` drops when `count=7` and blocked pushes write nothing.
  - Total updates equal accepted slots.
  - Order is preserved across pointer wrap.
  - With `BUQ_PERF_EN`, `stall_cnt` equals the number of blocked cycles.
- Push and pop in the same cycle with `count=6` and `in_valid=2'b11` → `count=7` next cycle, then `in_ready=0`.
